regfile_port_sequencer: RTL and testbench

//  Initiator side of the 32x64 register file port set (SA/SB/DA/D/W in, A/B out).

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_port_sequencer_if.sv | 29 ++
 rtl/regfile_cmd_fifo.sv | 59 +++++
 rtl/regfile_port_sequencer.sv | 127 ++++++++++++
 tb/tb_regfile_port_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file port sequencer:
// data/select widths, zero-register index, FSM state encoding and the queued command layout.
package regfile_pkg;

   localparam int DATA_W    = 64;
   localparam int ADDR_W    = 5;
   localparam int REG_COUNT = 32;

   localparam logic [ADDR_W-1:0] XZR_IDX = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_RESP  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] sa;
      logic [ADDR_W-1:0] sb;
      logic [ADDR_W-1:0] da;
      logic [DATA_W-1:0] data;
   } rf_cmd_t;

   function automatic logic is_xzr(input logic [ADDR_W-1:0] sel);
      return sel == XZR_IDX;
   endfunction

endpackage

// File: rtl/regfile_port_sequencer_if.sv
// Command (valid/ready) and response (valid/ready) channels between a command source
// and the register-file port sequencer.
interface regfile_port_sequencer_if;
   import regfile_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_sa;
   logic [ADDR_W-1:0] cmd_sb;
   logic [ADDR_W-1:0] cmd_da;
   logic [DATA_W-1:0] cmd_data;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_a;
   logic [DATA_W-1:0] rsp_b;

   modport master (
      output cmd_valid, cmd_write, cmd_sa, cmd_sb, cmd_da, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_a, rsp_b
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_sa, cmd_sb, cmd_da, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_a, rsp_b
   );

endinterface

// File: rtl/regfile_cmd_fifo.sv
// Small synchronous FIFO holding queued register-file commands; head entry is visible
// without a read strobe so the sequencer can decode and pop it in the same cycle.
module regfile_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem[rd_ptr_reg];

   // Entry storage carries no reset: validity is tracked by count_reg alone.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clock) begin
            if (push_ok && wr_ptr_reg == PTR_W'(gi)) begin
               mem[gi] <= wdata;
            end
         end
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/regfile_port_sequencer.sv
// Queues write/dual-read commands and plays them onto a 32x64 register file one at a time.
// Optional REGFILE_XZR_EN makes register 31 a hard-wired zero register.
module regfile_port_sequencer
   import regfile_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   regfile_port_sequencer_if.slave  bus,
   output logic [ADDR_W-1:0]        rf_SA,
   output logic [ADDR_W-1:0]        rf_SB,
   output logic [ADDR_W-1:0]        rf_DA,
   output logic [DATA_W-1:0]        rf_D,
   output logic                     rf_W,
   input  logic [DATA_W-1:0]        rf_A,
   input  logic [DATA_W-1:0]        rf_B,
   output logic                     busy
);

`ifdef REGFILE_XZR_EN
   localparam bit XZR_EN = 1'b1;
`else
   localparam bit XZR_EN = 1'b0;
`endif

   seq_state_t        state_reg;
   logic [ADDR_W-1:0] rf_sa_reg;
   logic [ADDR_W-1:0] rf_sb_reg;
   logic [ADDR_W-1:0] rf_da_reg;
   logic [DATA_W-1:0] rf_d_reg;
   logic              rf_w_reg;
   logic              rsp_valid_reg;
   logic [DATA_W-1:0] rsp_a_reg;
   logic [DATA_W-1:0] rsp_b_reg;

   rf_cmd_t                     in_cmd;
   rf_cmd_t                     head;
   logic [$bits(rf_cmd_t)-1:0]  head_bits;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        push;
   logic                        pop;

   assign in_cmd = '{write: bus.cmd_write, sa: bus.cmd_sa, sb: bus.cmd_sb,
                     da: bus.cmd_da, data: bus.cmd_data};
   assign head   = rf_cmd_t'(head_bits);

   // Ready is held low while reset is asserted so every output reads 0 during reset.
   assign bus.cmd_ready = reset & ~fifo_full;
   assign push          = bus.cmd_valid & bus.cmd_ready;
   assign pop           = (state_reg == ST_IDLE) & ~fifo_empty;

   regfile_cmd_fifo #(
      .WIDTH ($bits(rf_cmd_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .wdata (in_cmd),
      .pop   (pop),
      .rdata (head_bits),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         rf_sa_reg     <= '0;
         rf_sb_reg     <= '0;
         rf_da_reg     <= '0;
         rf_d_reg      <= '0;
         rf_w_reg      <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_a_reg     <= '0;
         rsp_b_reg     <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  if (head.write) begin
                     rf_da_reg <= head.da;
                     rf_d_reg  <= head.data;
                     // A zero-register write still walks through WRITE, just without a strobe.
                     rf_w_reg  <= ~(XZR_EN & is_xzr(head.da));
                     state_reg <= ST_WRITE;
                  end else begin
                     rf_sa_reg <= head.sa;
                     rf_sb_reg <= head.sb;
                     state_reg <= ST_READ;
                  end
               end
            end
            ST_WRITE: begin
               rf_w_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            ST_READ: begin
               rsp_a_reg     <= (XZR_EN && is_xzr(rf_sa_reg)) ? '0 : rf_A;
               rsp_b_reg     <= (XZR_EN && is_xzr(rf_sb_reg)) ? '0 : rf_B;
               rsp_valid_reg <= 1'b1;
               state_reg     <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign rf_SA         = rf_sa_reg;
   assign rf_SB         = rf_sb_reg;
   assign rf_DA         = rf_da_reg;
   assign rf_D          = rf_d_reg;
   assign rf_W          = rf_w_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_a     = rsp_a_reg;
   assign bus.rsp_b     = rsp_b_reg;
   assign busy          = (state_reg != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Directed and randomized bench for regfile_port_sequencer paired with a 32x64 register file model;
// expected read data comes from a shadow register array updated in command-acceptance order.
module tb_regfile_port_sequencer;

`ifdef REGFILE_XZR_EN
   localparam bit XZR = 1'b1;
`else
   localparam bit XZR = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  rf_SA, rf_SB, rf_DA;
   logic [63:0] rf_D, rf_A, rf_B;
   logic        rf_W;
   logic        busy;

   regfile_port_sequencer_if bus ();

   regfile_port_sequencer #(.FIFO_DEPTH(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .rf_SA (rf_SA),
      .rf_SB (rf_SB),
      .rf_DA (rf_DA),
      .rf_D  (rf_D),
      .rf_W  (rf_W),
      .rf_A  (rf_A),
      .rf_B  (rf_B),
      .busy  (busy)
   );

   initial begin
      #2;
      forever #5 clock = ~clock;
   end

   // 32x64 register file: synchronous write, combinational read.
   bit [63:0] rf_mem [32];
   always @(posedge clock) if (rf_W) rf_mem[rf_DA] <= rf_D;
   assign rf_A = rf_mem[rf_SA];
   assign rf_B = rf_mem[rf_SB];

   int w_pulses = 0;
   int w_double = 0;
   bit w_prev   = 1'b0;
   always @(posedge clock) begin
      if (rf_W) w_pulses <= w_pulses + 1;
      if (rf_W && w_prev) w_double <= w_double + 1;
      w_prev <= rf_W;
   end

   // Reference model
   bit [63:0]   shadow [32];
   bit [63:0]   snap   [32];
   logic [63:0] exp_a_q [$];
   logic [63:0] exp_b_q [$];
   int          exp_writes = 0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit wr, input logic [4:0] sa, input logic [4:0] sb,
                       input logic [4:0] da, input logic [63:0] data);
      int n;
      n = 0;
      bus.cmd_write = wr;
      bus.cmd_sa    = sa;
      bus.cmd_sb    = sb;
      bus.cmd_da    = da;
      bus.cmd_data  = data;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      if (!bus.cmd_ready) chk("push_timeout", 64'(bus.cmd_ready), 64'd1);
      @(posedge clock); #1;
      bus.cmd_valid = 1'b0;
      if (n < 100) begin
         if (wr) begin
            if (!(XZR && da == 5'd31)) begin
               shadow[da] = data;
               exp_writes++;
            end
         end else begin
            exp_a_q.push_back((XZR && sa == 5'd31) ? 64'd0 : shadow[sa]);
            exp_b_q.push_back((XZR && sb == 5'd31) ? 64'd0 : shadow[sb]);
         end
      end
   endtask

   task automatic get_rsp(input string tag, input int hold);
      int n;
      logic [63:0] ea, eb;
      n = 0;
      bus.rsp_ready = 1'b0;
      while (!bus.rsp_valid && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
      ea = (exp_a_q.size() > 0) ? exp_a_q.pop_front() : 64'd0;
      eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 64'd0;
      chk({tag, "_a"}, bus.rsp_a, ea);
      chk({tag, "_b"}, bus.rsp_b, eb);
      for (int i = 0; i < hold; i++) begin
         @(posedge clock); #1;
         chk({tag, "_hold_valid"}, 64'(bus.rsp_valid), 64'd1);
         chk({tag, "_hold_a"}, bus.rsp_a, ea);
         chk({tag, "_hold_b"}, bus.rsp_b, eb);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clock); #1;
      bus.rsp_ready = 1'b0;
      chk({tag, "_drop"}, 64'(bus.rsp_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int snap_writes;
      logic [4:0]  a, b;
      logic [63:0] d;

      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_sa    = '0;
      bus.cmd_sb    = '0;
      bus.cmd_da    = '0;
      bus.cmd_data  = '0;
      bus.rsp_ready = 1'b0;

      // 1: reset behaviour
      #10;
      chk("rst_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
      chk("rst_rf_W", 64'(rf_W), 64'd0);
      #5;
      reset = 1'b1;
      @(posedge clock); #1;
      chk("rst_rf_SA", 64'(rf_SA), 64'd0);
      chk("rst_rf_SB", 64'(rf_SB), 64'd0);
      chk("rst_rf_DA", 64'(rf_DA), 64'd0);
      chk("rst_rf_D", rf_D, 64'd0);
      chk("rst_rf_W_rel", 64'(rf_W), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);

      // 2: write then read, with latency
      push(1'b1, 5'd0, 5'd0, 5'd4, 64'd18);
      chk("t2_w_lat0", 64'(rf_W), 64'd0);
      @(posedge clock); #1;
      chk("t2_w_high", 64'(rf_W), 64'd1);
      chk("t2_w_da", 64'(rf_DA), 64'd4);
      chk("t2_w_d", rf_D, 64'd18);
      @(posedge clock); #1;
      chk("t2_w_low", 64'(rf_W), 64'd0);
      push(1'b0, 5'd4, 5'd4, 5'd0, 64'd0);
      @(posedge clock); #1;
      chk("t2_r_sa", 64'(rf_SA), 64'd4);
      chk("t2_r_sb", 64'(rf_SB), 64'd4);
      chk("t2_r_notyet", 64'(bus.rsp_valid), 64'd0);
      @(posedge clock); #1;
      chk("t2_r_valid_e2", 64'(bus.rsp_valid), 64'd1);
      chk("t2_r_a18", bus.rsp_a, 64'd18);
      get_rsp("t2", 0);

      // 3: back-to-back writes then read, order preserved
      push(1'b1, 5'd0, 5'd0, 5'd4, 64'd18);
      push(1'b1, 5'd0, 5'd0, 5'd6, 64'd100);
      push(1'b0, 5'd4, 5'd6, 5'd0, 64'd0);
      get_rsp("t3", 0);

      // 4: FIFO fills while response is held
      push(1'b0, 5'd4, 5'd6, 5'd0, 64'd0);
      push(1'b0, 5'd6, 5'd4, 5'd0, 64'd0);
      push(1'b0, 5'd4, 5'd4, 5'd0, 64'd0);
      chk("t4_ready_full", 64'(bus.cmd_ready), 64'd0);
      chk("t4_busy", 64'(busy), 64'd1);
      get_rsp("t4r1", 10);
      get_rsp("t4r2", 0);
      get_rsp("t4r3", 0);

      // 5: reset during WRITE drops the write and flushes the FIFO
      snap = shadow;
      snap_writes = exp_writes;
      push(1'b1, 5'd0, 5'd0, 5'd4, 64'h55);
      push(1'b1, 5'd0, 5'd0, 5'd6, 64'h77);
      chk("t5_in_write", 64'(rf_W), 64'd1);
      #1 reset = 1'b0;
      #1;
      chk("t5_w_async", 64'(rf_W), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_rf_D", rf_D, 64'd0);
      shadow = snap;
      exp_writes = snap_writes;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("t5_busy_after", 64'(busy), 64'd0);
      chk("t5_ready_after", 64'(bus.cmd_ready), 64'd1);
      push(1'b0, 5'd4, 5'd6, 5'd0, 64'd0);
      get_rsp("t5", 0);

      // 6: register 31 behaviour
      p0 = w_pulses;
      push(1'b1, 5'd0, 5'd0, 5'd31, 64'hFFFF);
      push(1'b0, 5'd31, 5'd4, 5'd0, 64'd0);
      get_rsp("t6", 0);
      chk("t6_w_pulses", 64'(w_pulses - p0), XZR ? 64'd0 : 64'd1);

      // 7: randomized traffic
      for (int it = 0; it < 40; it++) begin
         int nw;
         nw = int'($urandom_range(0, 2));
         for (int k = 0; k < nw; k++) begin
            a = 5'($urandom_range(0, 31));
            d = {$urandom(), $urandom()};
            push(1'b1, 5'd0, 5'd0, a, d);
         end
         a = 5'($urandom_range(0, 31));
         b = 5'($urandom_range(0, 31));
         push(1'b0, a, b, 5'd0, 64'd0);
         get_rsp("rnd", int'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clock);
      #1;
      chk("end_w_pulses", 64'(w_pulses), 64'(exp_writes));
      chk("end_w_double", 64'(w_double), 64'd0);
      chk("end_busy", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
